// File: rtl/slave_fifo_tx_arbiter_if.sv
// ----------------------------------------------------------------------------
// slave_fifo_tx_arbiter_if
//
// Merged transmit stream between the channel arbiter and the Slave FIFO
// read/write controller. The arbiter side looks like one show-ahead FIFO.
//
// Signals:
//   mux_rdrq   read request from the controller
//   mux_empty  merged empty flag (high whenever no word may be taken)
//   mux_q      merged show-ahead data word
//
// Modports:
//   master  arbiter side (sources empty/q, sinks rdrq)
//   slave   controller side (sources rdrq, sinks empty/q)
// ----------------------------------------------------------------------------
interface slave_fifo_tx_arbiter_if #(
    parameter int DW = 16
);
    logic          mux_rdrq;
    logic          mux_empty;
    logic [DW-1:0] mux_q;

    modport master (
        input  mux_rdrq,
        output mux_empty,
        output mux_q
    );

    modport slave (
        output mux_rdrq,
        input  mux_empty,
        input  mux_q
    );
endinterface

// File: rtl/slave_fifo_tx_arbiter.sv
// ----------------------------------------------------------------------------
// slave_fifo_tx_arbiter
//
// Shares the single Slave FIFO write path (EP6 direction) between N_CH local
// transmit channels. A channel raises ch_req once a complete message sits in
// its local show-ahead FIFO. The arbiter grants one channel round-robin,
// presents that FIFO as a single merged empty/q/rdrq stream, and keeps the
// grant until exactly one message length of words has been read, then pulses
// msg_done.
//
// Ports:
//   CLK            system clock
//   RST            asynchronous active-low reset
//   ch_req         per-channel "complete message ready"
//   ch_len         per-channel message length in words, 0 means 2^LEN_W
//   ch_empty       per-channel local FIFO empty flag
//   ch_q           per-channel local FIFO show-ahead data
//   ch_rdrq        per-channel local FIFO read request
//   hold           blocks new grants while the controller reads from host
//   mux            merged stream towards the Slave FIFO controller
//   grant          registered one-hot grant
//   grant_valid    a message transfer is in progress
//   msg_done       one-cycle pulse after the final word of a message
//   msg_abort      one-cycle pulse when the watchdog abandons a message
//                  (only with SLAVE_FIFO_TX_WATCHDOG_EN)
//   state_monitor  current FSM state
//
// Build option:
//   SLAVE_FIFO_TX_WATCHDOG_EN  adds a TO_W-bit stall watchdog, the ABORT
//                              state and the msg_abort output. Without it a
//                              stalled channel is waited on indefinitely.
// ----------------------------------------------------------------------------
module slave_fifo_tx_arbiter #(
    parameter int N_CH  = 4,
    parameter int DW    = 16,
    parameter int LEN_W = 8,
    parameter int TO_W  = 12
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [N_CH-1:0]         ch_req,
    input  logic [N_CH*LEN_W-1:0]   ch_len,
    input  logic [N_CH-1:0]         ch_empty,
    input  logic [N_CH*DW-1:0]      ch_q,
    output logic [N_CH-1:0]         ch_rdrq,
    input  logic                    hold,
    slave_fifo_tx_arbiter_if.master mux,
    output logic [N_CH-1:0]         grant,
    output logic                    grant_valid,
    output logic                    msg_done,
`ifdef SLAVE_FIFO_TX_WATCHDOG_EN
    output logic                    msg_abort,
`endif
    output logic [2:0]              state_monitor
);

    localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
    // One extra bit so a zero length field can load 2^LEN_W.
    localparam int CW = LEN_W + 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARB   = 3'd1;
    localparam logic [2:0] ST_XFER  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
`ifdef SLAVE_FIFO_TX_WATCHDOG_EN
    localparam logic [2:0] ST_ABORT = 3'd4;
`endif

    // Elaboration-time guard against unsupported configurations.
    if (N_CH < 2 || N_CH > 8 || DW < 1 || LEN_W < 1 || TO_W < 2) begin : g_bad_params
        $error("slave_fifo_tx_arbiter: parameter out of supported range");
    end

    logic [2:0]      state_q, state_d;
    logic [N_CH-1:0] grant_q, grant_d;
    logic            grant_valid_q, grant_valid_d;
    logic            msg_done_q, msg_done_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gidx_q, gidx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
`ifdef SLAVE_FIFO_TX_WATCHDOG_EN
    logic [TO_W-1:0] wdog_q, wdog_d;
    logic            msg_abort_q, msg_abort_d;
`endif

    logic [LEN_W-1:0] len_arr  [N_CH];
    logic [DW-1:0]    q_arr    [N_CH];
    logic [PW-1:0]    cand_idx [N_CH];
    logic             win_found;
    logic [PW-1:0]    win_idx;
    logic             in_xfer;
    logic             accept;
    logic [CW-1:0]    len_load;

    // Unpack the flat channel buses, build the rotated search order and
    // steer the read request to the granted channel only.
    genvar gi;
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
        assign len_arr[gi]  = ch_len[gi*LEN_W +: LEN_W];
        assign q_arr[gi]    = ch_q[gi*DW +: DW];
        // Candidate gi is pointer+gi+1 (mod N_CH): the channel that finished
        // last is examined last, which gives it lowest priority.
        assign cand_idx[gi] = PW'((int'(ptr_q) + gi + 1) % N_CH);
        assign ch_rdrq[gi]  = accept && (gidx_q == PW'(gi));
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (!win_found && ch_req[cand_idx[k]]) begin
                win_found = 1'b1;
                win_idx   = cand_idx[k];
            end
        end
    end

    assign len_load = (len_arr[win_idx] == '0) ? (CW'(1) << LEN_W)
                                               : {1'b0, len_arr[win_idx]};

    // The merged stream is only live in XFER; a zero counter also forces
    // empty so a message can never be over-read.
    assign in_xfer        = (state_q == ST_XFER);
    assign mux.mux_empty  = !in_xfer || ch_empty[gidx_q] || (cnt_q == '0);
    assign mux.mux_q      = in_xfer ? q_arr[gidx_q] : '0;
    assign accept         = mux.mux_rdrq && !mux.mux_empty;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        ptr_d         = ptr_q;
        gidx_d        = gidx_q;
        cnt_d         = cnt_q;
        msg_done_d    = 1'b0;
`ifdef SLAVE_FIFO_TX_WATCHDOG_EN
        wdog_d        = wdog_q;
        msg_abort_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!hold && (ch_req != '0)) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                // Requests may have vanished since IDLE; then give up quietly.
                if (win_found) begin
                    grant_d       = {{(N_CH-1){1'b0}}, 1'b1} << win_idx;
                    grant_valid_d = 1'b1;
                    gidx_d        = win_idx;
                    cnt_d         = len_load;
`ifdef SLAVE_FIFO_TX_WATCHDOG_EN
                    wdog_d        = '0;
`endif
                    state_d       = ST_XFER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                // hold and ch_req are deliberately ignored here.
                if (accept) begin
                    cnt_d = cnt_q - CW'(1);
`ifdef SLAVE_FIFO_TX_WATCHDOG_EN
                    wdog_d = '0;
`endif
                    if (cnt_q == CW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
`ifdef SLAVE_FIFO_TX_WATCHDOG_EN
                else if (wdog_q == '1) begin
                    state_d = ST_ABORT;
                end else begin
                    wdog_d = wdog_q + TO_W'(1);
                end
`endif
            end
            ST_DONE: begin
                msg_done_d    = 1'b1;
                grant_d       = '0;
                grant_valid_d = 1'b0;
                ptr_d         = gidx_q;
                state_d       = ST_IDLE;
            end
`ifdef SLAVE_FIFO_TX_WATCHDOG_EN
            ST_ABORT: begin
                msg_abort_d   = 1'b1;
                grant_d       = '0;
                grant_valid_d = 1'b0;
                ptr_d         = gidx_q;
                state_d       = ST_IDLE;
            end
`endif
            default: begin
                grant_d       = '0;
                grant_valid_d = 1'b0;
                state_d       = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            msg_done_q    <= 1'b0;
            ptr_q         <= PW'(N_CH - 1);
            gidx_q        <= '0;
            cnt_q         <= '0;
`ifdef SLAVE_FIFO_TX_WATCHDOG_EN
            wdog_q        <= '0;
            msg_abort_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            msg_done_q    <= msg_done_d;
            ptr_q         <= ptr_d;
            gidx_q        <= gidx_d;
            cnt_q         <= cnt_d;
`ifdef SLAVE_FIFO_TX_WATCHDOG_EN
            wdog_q        <= wdog_d;
            msg_abort_q   <= msg_abort_d;
`endif
        end
    end

    assign grant         = grant_q;
    assign grant_valid   = grant_valid_q;
    assign msg_done      = msg_done_q;
    assign state_monitor = state_q;
`ifdef SLAVE_FIFO_TX_WATCHDOG_EN
    assign msg_abort     = msg_abort_q;
`endif

endmodule

// File: tb/tb_slave_fifo_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_slave_fifo_tx_arbiter
//
// Channel FIFOs are modelled as queues. Every message loaded into a channel
// also pushes its words, in the order the arbiter must deliver them, onto a
// scoreboard queue; each accepted read on the merged stream pops and compares.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_slave_fifo_tx_arbiter;

    localparam int N_CH  = 4;
    localparam int DW    = 16;
    localparam int LEN_W = 8;
`ifdef SLAVE_FIFO_TX_WATCHDOG_EN
    localparam int TO_W  = 4;
`else
    localparam int TO_W  = 12;
`endif

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARB  = 3'd1;
    localparam logic [2:0] S_XFER = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;

    typedef struct packed {
        logic [2:0]    ch;
        logic [DW-1:0] data;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N_CH-1:0]       ch_req;
    logic [N_CH*LEN_W-1:0] ch_len;
    logic [N_CH-1:0]       ch_empty;
    logic [N_CH*DW-1:0]    ch_q;
    logic [N_CH-1:0]       ch_rdrq;
    logic                  hold;
    logic [N_CH-1:0]       grant;
    logic                  grant_valid;
    logic                  msg_done;
    logic [2:0]            state_monitor;
`ifdef SLAVE_FIFO_TX_WATCHDOG_EN
    logic                  msg_abort;
`endif

    logic [N_CH-1:0] stall;
    logic [N_CH-1:0] pop_pend;
    logic [DW-1:0]   fifo [N_CH][$];
    exp_t            exp_q [$];
    logic [N_CH-1:0] glog [$];
    logic            gv_prev;
    int              acc_cnt [N_CH];
    int              done_cnt;
    int              abort_cnt;
    int              n_vec;
    int              n_err;

    slave_fifo_tx_arbiter_if #(.DW(DW)) mux_if ();

    slave_fifo_tx_arbiter #(
        .N_CH(N_CH), .DW(DW), .LEN_W(LEN_W), .TO_W(TO_W)
    ) dut (
        .CLK           (clk),
        .RST           (rst_n),
        .ch_req        (ch_req),
        .ch_len        (ch_len),
        .ch_empty      (ch_empty),
        .ch_q          (ch_q),
        .ch_rdrq       (ch_rdrq),
        .hold          (hold),
        .mux           (mux_if),
        .grant         (grant),
        .grant_valid   (grant_valid),
        .msg_done      (msg_done),
`ifdef SLAVE_FIFO_TX_WATCHDOG_EN
        .msg_abort     (msg_abort),
`endif
        .state_monitor (state_monitor)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < N_CH; i++) begin
            ch_empty[i]          = stall[i] || (fifo[i].size() == 0);
            ch_q[i*DW +: DW]     = (fifo[i].size() != 0) ? fifo[i][0] : '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Load nw words into channel ch; the first nexp of them are expected out.
    task automatic load_msg(input int ch, input int nw, input logic [DW-1:0] base, input int nexp);
        exp_t e;
        for (int k = 0; k < nw; k++) begin
            fifo[ch].push_back(base + DW'(k));
            if (k < nexp) begin
                e.ch   = 3'(ch);
                e.data = base + DW'(k);
                exp_q.push_back(e);
            end
        end
        refresh();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || state_monitor != S_IDLE) && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, (n < budget), 1'b1);
        tick();
        tick();
    endtask

    task automatic wait_grants(input string tag, input int cnt, input int budget);
        int n = 0;
        while (glog.size() < cnt && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, (n < budget), 1'b1);
    endtask

    // Monitor: observe the merged stream mid-cycle, score accepted reads.
    always @(negedge clk) begin : mon
        exp_t e;
        pop_pend = '0;
        if (rst_n) begin
            if (msg_done) done_cnt++;
`ifdef SLAVE_FIFO_TX_WATCHDOG_EN
            if (msg_abort) abort_cnt++;
`endif
            if (grant_valid && !gv_prev) glog.push_back(grant);
            gv_prev = grant_valid;
            if (ch_rdrq != '0) begin
                check_eq("rdrq_vs_grant", ch_rdrq, grant);
                check_eq("rdrq_needs_mux_rdrq", mux_if.mux_rdrq, 1'b1);
                check_eq("rdrq_mux_empty", mux_if.mux_empty, 1'b0);
                for (int i = 0; i < N_CH; i++) begin
                    if (ch_rdrq[i]) begin
                        pop_pend[i] = 1'b1;
                        acc_cnt[i]++;
                        check_eq("rd_src_nonempty", ch_empty[i], 1'b0);
                    end
                end
                if (exp_q.size() == 0) begin
                    check_eq("rd_unexpected", ch_rdrq, '0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("rd_data", mux_if.mux_q, e.data);
                    check_eq("rd_grant", grant, N_CH'(1) << e.ch);
                end
            end
        end else begin
            gv_prev = 1'b0;
        end
    end

    // Channel FIFO model: apply the pops decided by the last accepted reads.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N_CH; i++) begin
            if (pop_pend[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
        end
        refresh();
    end

    initial begin : stim
        int d0;
        int a0;
        int n;
        logic [N_CH-1:0] exp_order [5];

        n_vec = 0; n_err = 0; done_cnt = 0; abort_cnt = 0; gv_prev = 1'b0;
        for (int i = 0; i < N_CH; i++) acc_cnt[i] = 0;
        rst_n = 1'b0; hold = 1'b0; ch_req = '0; ch_len = '0; stall = '0;
        pop_pend = '0; mux_if.mux_rdrq = 1'b0;
        refresh();

        // ---- reset state ----
        tick(); tick(); tick();
        check_eq("rst_state", state_monitor, S_IDLE);
        check_eq("rst_grant", grant, '0);
        check_eq("rst_grant_valid", grant_valid, 1'b0);
        check_eq("rst_msg_done", msg_done, 1'b0);
        check_eq("rst_mux_empty", mux_if.mux_empty, 1'b1);
        check_eq("rst_mux_q", mux_if.mux_q, '0);
        check_eq("rst_ch_rdrq", ch_rdrq, '0);
`ifdef SLAVE_FIFO_TX_WATCHDOG_EN
        check_eq("rst_msg_abort", msg_abort, 1'b0);
`endif
        rst_n = 1'b1;
        tick();

        // ---- single 3-word message on channel 0 ----
        ch_len[0*LEN_W +: LEN_W] = 8'd3;
        load_msg(0, 3, 16'hA001, 3);
        mux_if.mux_rdrq = 1'b1;
        ch_req = 4'b0001;
        tick();
        check_eq("t1_arb_state", state_monitor, S_ARB);
        check_eq("t1_arb_grant", grant, '0);
        tick();
        check_eq("t1_grant", grant, 4'b0001);
        check_eq("t1_grant_valid", grant_valid, 1'b1);
        check_eq("t1_xfer_state", state_monitor, S_XFER);
        check_eq("t1_first_word", mux_if.mux_q, 16'hA001);
        ch_req = '0;
        tick(); tick(); tick();
        check_eq("t1_done_state", state_monitor, S_DONE);
        check_eq("t1_done_not_yet", msg_done, 1'b0);
        check_eq("t1_rdrq_cycles", acc_cnt[0], 3);
        tick();
        check_eq("t1_msg_done", msg_done, 1'b1);
        check_eq("t1_grant_clr", grant, '0);
        check_eq("t1_gv_clr", grant_valid, 1'b0);
        tick();
        check_eq("t1_msg_done_pulse", msg_done, 1'b0);
        check_eq("t1_done_count", done_cnt, 1);

        // ---- round robin, all lengths 2; channel 0 just finished ----
        glog.delete();
        d0 = done_cnt;
        for (int i = 0; i < N_CH; i++) ch_len[i*LEN_W +: LEN_W] = 8'd2;
        load_msg(1, 2, 16'h1100, 2);
        load_msg(2, 2, 16'h1200, 2);
        load_msg(3, 2, 16'h1300, 2);
        load_msg(0, 2, 16'h1000, 2);
        load_msg(1, 2, 16'h1110, 2);
        ch_req = 4'b1111;
        wait_grants("rr_grant_timeout", 5, 200);
        ch_req = '0;
        wait_idle("rr_idle_timeout", 200);
        exp_order[0] = 4'b0010; exp_order[1] = 4'b0100; exp_order[2] = 4'b1000;
        exp_order[3] = 4'b0001; exp_order[4] = 4'b0010;
        for (int k = 0; k < 5; k++)
            check_eq("rr_order", (glog.size() > k) ? glog[k] : '0, exp_order[k]);
        check_eq("rr_grant_count", glog.size(), 5);
        check_eq("rr_done_count", done_cnt - d0, 5);

        // ---- hold ----
        glog.delete();
        d0 = done_cnt;
        a0 = acc_cnt[2];
        hold = 1'b1;
        ch_len[2*LEN_W +: LEN_W] = 8'd3;
        load_msg(2, 3, 16'h2200, 3);
        ch_req = 4'b0100;
        tick(); tick(); tick(); tick();
        check_eq("hold_no_grant", grant_valid, 1'b0);
        check_eq("hold_idle", state_monitor, S_IDLE);
        hold = 1'b0;
        tick();
        check_eq("hold_rel_arb", state_monitor, S_ARB);
        tick();
        check_eq("hold_rel_grant", grant, 4'b0100);
        ch_req = '0;
        tick();
        hold = 1'b1;
        wait_idle("hold_mid_timeout", 50);
        check_eq("hold_mid_words", acc_cnt[2] - a0, 3);
        check_eq("hold_mid_done", done_cnt - d0, 1);
        hold = 1'b0;

        // ---- length 0 (256 words) with stalls on both sides ----
        d0 = done_cnt;
        a0 = acc_cnt[3];
        ch_len[3*LEN_W +: LEN_W] = 8'd0;
        load_msg(3, 260, 16'h3000, 256);
        ch_req = 4'b1000;
        n = 0;
        while ((exp_q.size() != 0 || state_monitor != S_IDLE) && n < 3000) begin
            if (grant_valid) ch_req = '0;
            stall[3] = ($urandom_range(0, 3) == 0);
            mux_if.mux_rdrq = ($urandom_range(0, 3) != 0);
            refresh();
            tick();
            n++;
        end
        check_eq("len0_timeout", (n < 3000), 1'b1);
        stall = '0;
        mux_if.mux_rdrq = 1'b1;
        refresh();
        tick(); tick();
        check_eq("len0_words", acc_cnt[3] - a0, 256);
        check_eq("len0_fifo_left", fifo[3].size(), 4);
        check_eq("len0_empty_after", mux_if.mux_empty, 1'b1);
        check_eq("len0_done", done_cnt - d0, 1);
        fifo[3].delete();
        refresh();

        // ---- reset in the middle of a 10-word message ----
        d0 = done_cnt;
        a0 = acc_cnt[1];
        ch_len[1*LEN_W +: LEN_W] = 8'd10;
        load_msg(1, 10, 16'h4100, 10);
        ch_req = 4'b0010;
        n = 0;
        while ((acc_cnt[1] - a0) < 5 && n < 100) begin
            tick();
            n++;
        end
        check_eq("mid_rst_reach5", (n < 100), 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_grant", grant, '0);
        check_eq("mid_rst_gv", grant_valid, 1'b0);
        check_eq("mid_rst_done", msg_done, 1'b0);
        check_eq("mid_rst_state", state_monitor, S_IDLE);
        check_eq("mid_rst_rdrq", ch_rdrq, '0);
        exp_q.delete();
        fifo[1].delete();
        ch_req = '0;
        refresh();
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check_eq("mid_rst_words", acc_cnt[1] - a0, 5);
        check_eq("mid_rst_no_done", done_cnt - d0, 0);

        glog.delete();
        ch_len[0*LEN_W +: LEN_W] = 8'd1;
        ch_len[1*LEN_W +: LEN_W] = 8'd1;
        load_msg(0, 1, 16'h5000, 1);
        load_msg(1, 1, 16'h5100, 1);
        ch_req = 4'b0011;
        wait_grants("post_rst_timeout", 2, 100);
        ch_req = '0;
        wait_idle("post_rst_idle", 100);
        check_eq("post_rst_first", (glog.size() > 0) ? glog[0] : '0, 4'b0001);
        check_eq("post_rst_second", (glog.size() > 1) ? glog[1] : '0, 4'b0010);

`ifdef SLAVE_FIFO_TX_WATCHDOG_EN
        // ---- watchdog: channel 2 stalls empty, channel 0 waits behind it ----
        glog.delete();
        d0 = done_cnt;
        a0 = acc_cnt[2];
        stall[2] = 1'b1;
        ch_len[2*LEN_W +: LEN_W] = 8'd4;
        load_msg(2, 4, 16'h6200, 0);
        load_msg(0, 1, 16'h6000, 1);
        ch_req = 4'b0101;
        wait_grants("wd_first_grant", 1, 50);
        check_eq("wd_first_is_ch2", (glog.size() > 0) ? glog[0] : '0, 4'b0100);
        ch_req = 4'b0001;
        wait_grants("wd_second_grant", 2, 100);
        check_eq("wd_abort_once", abort_cnt, 1);
        check_eq("wd_second_is_ch0", (glog.size() > 1) ? glog[1] : '0, 4'b0001);
        ch_req = '0;
        wait_idle("wd_idle", 100);
        check_eq("wd_no_words_ch2", acc_cnt[2] - a0, 0);
        check_eq("wd_done_only_ch0", done_cnt - d0, 1);
        check_eq("wd_abort_total", abort_cnt, 1);
        stall = '0;
        fifo[2].delete();
        refresh();
`endif

        check_eq("final_scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
